// File: rtl/vending_core_multi.sv
// vending_core_multi: parametrised vending-machine controller core.
//   Accumulates coin credit up to MAX_CREDIT, latches an item from a packed
//   price table and vends on confirm. Change or a refund is paid out one coin
//   at a time, largest first, with DISP_GAP cycles between coin-return pulses.
// Optional feature macro: VEND_STOCK_EN
//   When defined, the core keeps one stock counter per item. Confirming an
//   empty item raises led_soldout_o, and restock_i reloads every counter.
//   When undefined, led_soldout_o is tied low and restock_i is ignored.
// Ports:
//   clk_i, rst_ni                 clock; asynchronous active-low reset
//   sw_item_i                     item select, sampled only in SELECT
//   coin_50_i/coin_25_i/coin_10_i one-cycle coin pulses
//   confirm_i, cancel_i           one-cycle finalise/acknowledge and abort pulses
//   restock_i                     one-cycle stock reload pulse
//   credit_o, price_o, change_o   credit so far, price of latched item, change owed
//   state_o                       SELECT=0 COLLECT=1 VEND=2 PAYOUT=3 DONE=4
//   led_purchase_o/led_insuff_o/led_soldout_o  status LEDs
//   coin_reject_o, vend_o         one-cycle pulses
//   ret_50_o/ret_25_o/ret_10_o/ret_5_o  one-cycle coin-return pulses
module vending_core_multi #(
   parameter int unsigned NUM_ITEMS  = 4,
   parameter int unsigned CREDIT_W   = 8,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd135, 8'd100, 8'd75, 8'd50},
   parameter int unsigned MAX_CREDIT = 200,
   parameter int unsigned DISP_GAP   = 4,
   parameter int unsigned STOCK_W    = 4,
   parameter int unsigned STOCK_INIT = 9,
   localparam int unsigned ItemW     = $clog2(NUM_ITEMS)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [ItemW-1:0]    sw_item_i,
   input  logic                coin_50_i,
   input  logic                coin_25_i,
   input  logic                coin_10_i,
   input  logic                confirm_i,
   input  logic                cancel_i,
   input  logic                restock_i,
   output logic [CREDIT_W-1:0] credit_o,
   output logic [CREDIT_W-1:0] price_o,
   output logic [CREDIT_W-1:0] change_o,
   output logic [2:0]          state_o,
   output logic                led_purchase_o,
   output logic                led_insuff_o,
   output logic                led_soldout_o,
   output logic                coin_reject_o,
   output logic                vend_o,
   output logic                ret_50_o,
   output logic                ret_25_o,
   output logic                ret_10_o,
   output logic                ret_5_o
);

   localparam int unsigned GapW = $clog2(DISP_GAP);
   localparam logic [CREDIT_W:0] MaxCred = (CREDIT_W+1)'(MAX_CREDIT);

   typedef enum logic [2:0] {
      StSelect  = 3'd0,
      StCollect = 3'd1,
      StVend    = 3'd2,
      StPayout  = 3'd3,
      StDone    = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [ItemW-1:0]    item_q, item_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] change_q, change_d;
   logic [GapW-1:0]     gap_q, gap_d;
   logic                purchase_q, purchase_d;
   logic                insuff_q, insuff_d;
   logic                soldout_q, soldout_d;
   logic                reject_q, reject_d;
   logic                vend_q, vend_d;
   logic [3:0]          ret_q, ret_d;  // {50, 25, 10, 5}

   logic [CREDIT_W-1:0] price_w, coin_val, pay_val;
   logic [CREDIT_W:0]   credit_sum;
   logic                coin_any, coin_ok, stock_empty;

   assign price_w = PRICES[int'(item_q)*CREDIT_W +: CREDIT_W];

   // Simultaneous coins: only the most valuable one is counted.
   always_comb begin
      coin_val = '0;
      if (coin_50_i)      coin_val = CREDIT_W'(50);
      else if (coin_25_i) coin_val = CREDIT_W'(25);
      else if (coin_10_i) coin_val = CREDIT_W'(10);
   end

   assign coin_any   = coin_50_i | coin_25_i | coin_10_i;
   assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
   assign coin_ok    = coin_any && (credit_sum <= MaxCred);

   // Greedy coin choice; change is always a multiple of 5.
   always_comb begin
      if (change_q >= CREDIT_W'(50))      pay_val = CREDIT_W'(50);
      else if (change_q >= CREDIT_W'(25)) pay_val = CREDIT_W'(25);
      else if (change_q >= CREDIT_W'(10)) pay_val = CREDIT_W'(10);
      else                                pay_val = CREDIT_W'(5);
   end

`ifdef VEND_STOCK_EN
   logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
   logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
   assign stock_empty = (stock_q[item_q] == '0);
`else
   logic unused_restock;
   assign unused_restock = restock_i;
   assign stock_empty    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      item_d     = item_q;
      credit_d   = credit_q;
      change_d   = change_q;
      gap_d      = gap_q;
      purchase_d = purchase_q;
      insuff_d   = insuff_q;
      soldout_d  = soldout_q;
      reject_d   = 1'b0;
      vend_d     = 1'b0;
      ret_d      = 4'b0000;
`ifdef VEND_STOCK_EN
      stock_d    = stock_q;
`endif
      unique case (state_q)
         StSelect: begin
            item_d = sw_item_i;
            if (coin_any) begin
               insuff_d  = 1'b0;
               soldout_d = 1'b0;
               if (coin_ok) begin
                  credit_d = credit_sum[CREDIT_W-1:0];
                  state_d  = StCollect;
               end else begin
                  reject_d = 1'b1;
               end
            end else if (confirm_i) begin
               insuff_d = 1'b1;
            end
         end
         StCollect: begin
            if (cancel_i) begin
               change_d  = credit_q;
               credit_d  = '0;
               insuff_d  = 1'b0;
               soldout_d = 1'b0;
               gap_d     = '0;
               state_d   = StPayout;
            end else if (coin_any) begin
               insuff_d  = 1'b0;
               soldout_d = 1'b0;
               if (coin_ok) credit_d = credit_sum[CREDIT_W-1:0];
               else         reject_d = 1'b1;
            end else if (confirm_i) begin
               // Sold-out takes precedence over the credit check.
               if (stock_empty)              soldout_d = 1'b1;
               else if (credit_q >= price_w) state_d   = StVend;
               else                          insuff_d  = 1'b1;
            end
         end
         StVend: begin
            vend_d     = 1'b1;
            purchase_d = 1'b1;
            change_d   = credit_q - price_w;
            credit_d   = '0;
            gap_d      = '0;
            reject_d   = coin_any;
            state_d    = StPayout;
`ifdef VEND_STOCK_EN
            stock_d[item_q] = stock_q[item_q] - 1'b1;
`endif
         end
         StPayout: begin
            reject_d = coin_any;
            if (change_q == '0) begin
               state_d = purchase_q ? StDone : StSelect;
            end else if (gap_q == '0) begin
               ret_d    = {pay_val == CREDIT_W'(50), pay_val == CREDIT_W'(25),
                           pay_val == CREDIT_W'(10), pay_val == CREDIT_W'(5)};
               change_d = change_q - pay_val;
               gap_d    = GapW'(DISP_GAP - 1);
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         StDone: begin
            reject_d = coin_any;
            if (confirm_i) begin
               purchase_d = 1'b0;
               state_d    = StSelect;
            end
         end
         default: state_d = StSelect;
      endcase
`ifdef VEND_STOCK_EN
      if (restock_i) begin
         for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
         soldout_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StSelect;
         item_q     <= '0;
         credit_q   <= '0;
         change_q   <= '0;
         gap_q      <= '0;
         purchase_q <= 1'b0;
         insuff_q   <= 1'b0;
         soldout_q  <= 1'b0;
         reject_q   <= 1'b0;
         vend_q     <= 1'b0;
         ret_q      <= 4'b0000;
      end else begin
         state_q    <= state_d;
         item_q     <= item_d;
         credit_q   <= credit_d;
         change_q   <= change_d;
         gap_q      <= gap_d;
         purchase_q <= purchase_d;
         insuff_q   <= insuff_d;
         soldout_q  <= soldout_d;
         reject_q   <= reject_d;
         vend_q     <= vend_d;
         ret_q      <= ret_d;
      end
   end

`ifdef VEND_STOCK_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      end else begin
         stock_q <= stock_d;
      end
   end
`endif

   assign credit_o       = credit_q;
   assign price_o        = price_w;
   assign change_o       = change_q;
   assign state_o        = state_q;
   assign led_purchase_o = purchase_q;
   assign led_insuff_o   = insuff_q;
   assign led_soldout_o  = soldout_q;
   assign coin_reject_o  = reject_q;
   assign vend_o         = vend_q;
   assign {ret_50_o, ret_25_o, ret_10_o, ret_5_o} = ret_q;

endmodule

// File: tb/tb_vending_core_multi.sv
// Self-checking bench for vending_core_multi: table-driven cycle vectors for
// the basic purchase, insufficient-credit and saturation paths, followed by
// hand-written sequences for payout timing, cancel refund and mid-payout reset.
module tb_vending_core_multi;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] sw_item = '0;
   logic       c50 = 0, c25 = 0, c10 = 0, confirm = 0, cancel = 0, restock = 0;
   logic [7:0] credit, price, change;
   logic [2:0] state;
   logic       led_purchase, led_insuff, led_soldout, coin_reject, vend;
   logic       r50, r25, r10, r5;

   int errors = 0;
   int checks = 0;
   int vend_cnt = 0;
   int ret_cnt = 0;

   always #5 clk = ~clk;

   vending_core_multi #(
`ifdef VEND_STOCK_EN
      .STOCK_INIT(1)
`else
      .STOCK_INIT(9)
`endif
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .sw_item_i(sw_item),
      .coin_50_i(c50), .coin_25_i(c25), .coin_10_i(c10),
      .confirm_i(confirm), .cancel_i(cancel), .restock_i(restock),
      .credit_o(credit), .price_o(price), .change_o(change), .state_o(state),
      .led_purchase_o(led_purchase), .led_insuff_o(led_insuff),
      .led_soldout_o(led_soldout), .coin_reject_o(coin_reject), .vend_o(vend),
      .ret_50_o(r50), .ret_25_o(r25), .ret_10_o(r10), .ret_5_o(r5)
   );

   always @(negedge clk) begin
      if (vend) vend_cnt++;
      ret_cnt += int'(r50) + int'(r25) + int'(r10) + int'(r5);
   end

   typedef struct {
      logic [1:0] sw;
      logic [2:0] coin;  // {50, 25, 10}
      logic       cf;
      logic       cn;
      logic [2:0] st;
      logic [7:0] cr;
      logic [7:0] ch;
      logic [3:0] fl;    // {led_purchase, led_insuff, coin_reject, vend}
      logic [3:0] ret;   // {50, 25, 10, 5}
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [1:0] sw, logic [2:0] coin, logic cf, logic cn,
                               logic [2:0] st, logic [7:0] cr, logic [7:0] ch,
                               logic [3:0] fl, logic [3:0] ret);
      vec_t v;
      v.sw = sw; v.coin = coin; v.cf = cf; v.cn = cn;
      v.st = st; v.cr = cr; v.ch = ch; v.fl = fl; v.ret = ret;
      return v;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic drive(input logic [1:0] sw, input logic [2:0] coin, input logic cf,
                        input logic cn, input logic rs);
      sw_item = sw;
      {c50, c25, c10} = coin;
      confirm = cf; cancel = cn; restock = rs;
      @(posedge clk);
      #1;
      {c50, c25, c10} = 3'b000;
      confirm = 0; cancel = 0; restock = 0;
   endtask

   task automatic idle();
      drive(sw_item, 3'b000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int vc, r10c, r5c, donec, npulse, ch10;
      int base;

      // T1 / T4 as cycle vectors; item 0 costs 50.
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,   0,   0, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 3'b010, 0, 0, 1,  25,   0, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 3'b000, 1, 0, 1,  25,   0, 4'b0100, 4'b0000));
      vecs.push_back(mk(0, 3'b010, 0, 0, 1,  50,   0, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 3'b000, 1, 0, 2,  50,   0, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 3'b000, 0, 0, 3,   0,   0, 4'b1001, 4'b0000));
      vecs.push_back(mk(0, 3'b000, 0, 0, 4,   0,   0, 4'b1000, 4'b0000));
      vecs.push_back(mk(0, 3'b000, 1, 0, 0,   0,   0, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 3'b000, 1, 0, 0,   0,   0, 4'b0100, 4'b0000));
      vecs.push_back(mk(0, 3'b100, 0, 0, 1,  50,   0, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 3'b101, 0, 0, 1, 100,   0, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 3'b100, 0, 0, 1, 150,   0, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 3'b100, 0, 0, 1, 200,   0, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 3'b001, 0, 0, 1, 200,   0, 4'b0010, 4'b0000));
      vecs.push_back(mk(0, 3'b010, 0, 0, 1, 200,   0, 4'b0010, 4'b0000));
      vecs.push_back(mk(0, 3'b000, 0, 0, 1, 200,   0, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 3'b000, 1, 0, 2, 200,   0, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 3'b000, 0, 0, 3,   0, 150, 4'b1001, 4'b0000));
      vecs.push_back(mk(0, 3'b000, 0, 0, 3,   0, 100, 4'b1000, 4'b1000));

      do_reset();
      chk("reset state", int'(state), 0);
      chk("reset credit", int'(credit), 0);
      chk("reset price", int'(price), 50);
      chk("reset flags", int'({led_purchase, led_insuff, led_soldout, coin_reject, vend}), 0);

      foreach (vecs[i]) begin
         drive(vecs[i].sw, vecs[i].coin, vecs[i].cf, vecs[i].cn, 1'b0);
         checks++;
         if (state != vecs[i].st || credit != vecs[i].cr || change != vecs[i].ch ||
             {led_purchase, led_insuff, coin_reject, vend} != vecs[i].fl ||
             {r50, r25, r10, r5} != vecs[i].ret || led_soldout !== 1'b0) begin
            errors++;
            $display("FAIL vec%0d: got st=%0d cr=%0d ch=%0d fl=%b ret=%b so=%b, expected st=%0d cr=%0d ch=%0d fl=%b ret=%b so=0",
                     i, state, credit, change, {led_purchase, led_insuff, coin_reject, vend},
                     {r50, r25, r10, r5}, led_soldout, vecs[i].st, vecs[i].cr, vecs[i].ch,
                     vecs[i].fl, vecs[i].ret);
         end
      end

      // T2: item 3 (135) paid with 150 -> ret_10 then ret_5, DISP_GAP apart.
      do_reset();
      repeat (3) drive(2'd3, 3'b100, 0, 0, 0);
      chk("t2 price", int'(price), 135);
      chk("t2 credit", int'(credit), 150);
      drive(2'd3, 3'b000, 1, 0, 0);
      vc = -1; r10c = -1; r5c = -1; donec = -1; npulse = 0; ch10 = -1;
      for (int c = 1; c <= 40; c++) begin
         idle();
         if (vend) vc = c;
         if (r10) begin r10c = c; ch10 = int'(change); end
         if (r5) r5c = c;
         npulse += int'(r50) + int'(r25) + int'(r10) + int'(r5);
         if (state == 3'd4) begin donec = c; break; end
      end
      chk("t2 vend cycle", vc, 1);
      chk("t2 ret10 cycle", r10c, 2);
      chk("t2 change after ret10", ch10, 5);
      chk("t2 ret5 cycle", r5c, 6);
      chk("t2 pulse count", npulse, 2);
      chk("t2 done cycle", donec, 7);

      // T3: cancel refunds 50; item frozen at first coin.
      do_reset();
      base = vend_cnt;
      drive(2'd1, 3'b100, 0, 0, 0);
      chk("t3 price", int'(price), 75);
      drive(2'd2, 3'b000, 0, 0, 0);
      chk("t3 price frozen", int'(price), 75);
      drive(2'd2, 3'b000, 0, 1, 0);
      chk("t3 state payout", int'(state), 3);
      chk("t3 refund owed", int'(change), 50);
      chk("t3 credit", int'(credit), 0);
      idle();
      chk("t3 ret50", int'({r50, r25, r10, r5}), 8);
      chk("t3 change", int'(change), 0);
      idle();
      chk("t3 back to select", int'(state), 0);
      chk("t3 no vend", vend_cnt - base, 0);

      // T6: reset mid-payout of 85 discards remaining change.
      do_reset();
      drive(2'd0, 3'b100, 0, 0, 0);
      drive(2'd0, 3'b010, 0, 0, 0);
      drive(2'd0, 3'b001, 0, 0, 0);
      chk("t6 credit", int'(credit), 85);
      drive(2'd0, 3'b000, 0, 1, 0);
      chk("t6 owed", int'(change), 85);
      idle();
      chk("t6 first ret", int'({r50, r25, r10, r5}), 8);
      chk("t6 owed after", int'(change), 35);
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("t6 async state", int'(state), 0);
      chk("t6 async outputs", int'({credit, change, led_purchase, led_insuff, led_soldout,
                                    coin_reject, vend, r50, r25, r10, r5}), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      base = ret_cnt;
      repeat (12) idle();
      chk("t6 no more rets", ret_cnt - base, 0);
      chk("t6 idle select", int'(state), 0);

`ifdef VEND_STOCK_EN
      // T5: stock of one per item.
      do_reset();
      drive(2'd0, 3'b100, 0, 0, 0);
      drive(2'd0, 3'b000, 1, 0, 0);
      idle();
      idle();
      drive(2'd0, 3'b000, 1, 0, 0);
      drive(2'd0, 3'b100, 0, 0, 0);
      drive(2'd0, 3'b000, 1, 0, 0);
      chk("t5 soldout led", int'(led_soldout), 1);
      chk("t5 stays collect", int'(state), 1);
      drive(2'd0, 3'b000, 0, 0, 1);
      chk("t5 restock clears", int'(led_soldout), 0);
      drive(2'd0, 3'b000, 1, 0, 0);
      chk("t5 vends after restock", int'(state), 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
